// File: rtl/mem_responder_pipe.sv
// mem_responder_pipe: responder end of a mem request/response val/rdy stream pair.
// Performs reads and writes on an internal word array at request accept and
// returns in-order responses after a fixed latency. A small response queue
// absorbs response-side backpressure.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   reqstream_val/rdy           request handshake (rdy has a same-cycle deq bypass)
//   reqstream_msg_type          0 read, 1 write, 2 init, 3..7 treated as read
//   reqstream_msg_opaque        tag echoed in the response
//   reqstream_msg_addr          byte address (wraps modulo 4*p_mem_words)
//   reqstream_msg_len           0 word, 1 byte, 2 halfword
//   reqstream_msg_data          write data, LSB-aligned
//   respstream_val/rdy          response handshake
//   respstream_msg_type/opaque/len  echoed request fields
//   respstream_msg_data         read data (LSB-aligned, zero-extended), 0 for writes
module mem_responder_pipe #(
  parameter int unsigned p_mem_words = 256,
  parameter int unsigned p_latency   = 2,
  parameter int unsigned p_depth     = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        reqstream_val,
  output logic        reqstream_rdy,
  input  logic [2:0]  reqstream_msg_type,
  input  logic [7:0]  reqstream_msg_opaque,
  input  logic [31:0] reqstream_msg_addr,
  input  logic [1:0]  reqstream_msg_len,
  input  logic [31:0] reqstream_msg_data,

  output logic        respstream_val,
  input  logic        respstream_rdy,
  output logic [2:0]  respstream_msg_type,
  output logic [7:0]  respstream_msg_opaque,
  output logic [1:0]  respstream_msg_len,
  output logic [31:0] respstream_msg_data
);

  localparam int unsigned AW = (p_mem_words > 1) ? $clog2(p_mem_words) : 1;
  localparam int unsigned PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CW = $clog2(p_depth + 1);
  localparam int unsigned TW = 3;

  typedef struct packed {
    logic [2:0]    typ;
    logic [7:0]    opaque;
    logic [1:0]    len;
    logic [31:0]   data;
    logic [TW-1:0] cd;
  } entry_t;

  logic [31:0]   mem_q [p_mem_words];
  entry_t        q_q   [p_depth];
  entry_t        q_d   [p_depth];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] occ_q, occ_d;

  logic          enq, deq, head_ready;
  entry_t        head;
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_off;
  logic          is_write;
  logic [31:0]   rd_word, rd_shift, rd_data, wr_data;
  logic [3:0]    wr_be;
  logic          unused_addr_bits;

  // Address bits above the array size are ignored (address wrap).
  assign unused_addr_bits = ^reqstream_msg_addr[31:AW+2];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  // Request decode, combinational read and write lane selection
  always_comb begin
    word_idx = reqstream_msg_addr[AW+1:2];
    byte_off = reqstream_msg_addr[1:0];
    is_write = (reqstream_msg_type == 3'd1) || (reqstream_msg_type == 3'd2);
    rd_word  = mem_q[word_idx];
    rd_shift = rd_word >> {byte_off, 3'b000};
    rd_data  = rd_word;
    wr_be    = 4'hF;
    wr_data  = reqstream_msg_data;
    unique case (reqstream_msg_len)
      2'd1: begin
        rd_data = rd_shift & 32'h0000_00FF;
        wr_be   = 4'b0001 << byte_off;
        wr_data = reqstream_msg_data << {byte_off, 3'b000};
      end
      2'd2: begin
        rd_data = rd_shift & 32'h0000_FFFF;
        // The upper lane falls off the word when the offset is 3.
        wr_be   = 4'b0011 << byte_off;
        wr_data = reqstream_msg_data << {byte_off, 3'b000};
      end
      default: begin
        rd_data = rd_word;
        wr_be   = 4'hF;
        wr_data = reqstream_msg_data;
      end
    endcase
  end

  // Handshakes; a full queue still accepts when the head leaves this cycle
  always_comb begin
    head           = q_q[rptr_q];
    head_ready     = (occ_q != '0) && (head.cd == '0);
    respstream_val = !reset && head_ready;
    deq            = respstream_val && respstream_rdy;
    reqstream_rdy  = !reset && ((occ_q < CW'(p_depth)) ||
                                ((occ_q == CW'(p_depth)) && deq));
    enq            = reqstream_val && reqstream_rdy;
  end

  // Response fields are forced to zero while reset is held
  always_comb begin
    respstream_msg_type   = '0;
    respstream_msg_opaque = '0;
    respstream_msg_len    = '0;
    respstream_msg_data   = '0;
    if (!reset) begin
      respstream_msg_type   = head.typ;
      respstream_msg_opaque = head.opaque;
      respstream_msg_len    = head.len;
      respstream_msg_data   = head.data;
    end
  end

  // Queue next state: age every pending entry, then enqueue at the write pointer
  always_comb begin
    for (int i = 0; i < int'(p_depth); i++) begin
      q_d[i] = q_q[i];
      if (q_q[i].cd != '0) q_d[i].cd = q_q[i].cd - TW'(1);
    end
    if (enq) begin
      q_d[wptr_q].typ    = reqstream_msg_type;
      q_d[wptr_q].opaque = reqstream_msg_opaque;
      q_d[wptr_q].len    = reqstream_msg_len;
      q_d[wptr_q].data   = is_write ? 32'd0 : rd_data;
      q_d[wptr_q].cd     = TW'(p_latency - 1);
    end
    rptr_d = deq ? ptr_inc(rptr_q) : rptr_q;
    wptr_d = enq ? ptr_inc(wptr_q) : wptr_q;
    unique case ({enq, deq})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr_q <= '0;
      wptr_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < int'(p_depth); i++) q_q[i] <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      occ_q  <= occ_d;
      for (int i = 0; i < int'(p_depth); i++) q_q[i] <= q_d[i];
    end
  end

  // Word array: not reset, writes commit at the accept edge
  always_ff @(posedge clk) begin
    if (enq && is_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/mem_responder_pipe.md
Name: mem_responder_pipe

Overview:
- Synthesizable data/instruction memory responder: the responder end of the mem request/response val/rdy streams that the pipelined processor drives from its imem and dmem ports.
- Accepts read/write requests, performs the access on an internal word array, and returns in-order responses after a configurable fixed latency.
- Buffers outstanding responses so the processor may stall the response stream (backpressure) without losing data.
- Used as the memory in processor unit and integration benches, and as a small on-chip scratchpad.

Parameters:
p_mem_words, 256, number of 32-bit words in the array; must be a power of 2.
p_latency, 2, cycles from the request-accept edge to the earliest response-valid cycle; legal range 1..8.
p_depth, 4, maximum outstanding requests (in flight plus completed but not yet consumed); must be at least 1.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
reqstream_val  in  1  request valid
reqstream_rdy  out  1  request ready
reqstream_msg_type  in  3  0 = read, 1 = write, 2 = init (write with no side-effect differences)
reqstream_msg_opaque  in  8  tag echoed in the response
reqstream_msg_addr  in  32  byte address
reqstream_msg_len  in  2  0 = 4 bytes, 1 = 1 byte, 2 = 2 bytes
reqstream_msg_data  in  32  write data, LSB-aligned
respstream_val  out  1  response valid
respstream_rdy  in  1  response ready
respstream_msg_type  out  3  echoed request type
respstream_msg_opaque  out  8  echoed opaque tag
respstream_msg_len  out  2  echoed length
respstream_msg_data  out  32  read data, LSB-aligned, zero-extended; 0 for write and init

Behaviour:
- Reset:
  - Asserting reset clears the response queue and all countdown counters.
  - While reset is asserted: reqstream_rdy = 0, respstream_val = 0, all respstream_msg fields = 0.
  - Memory array contents are not reset.
  - A reset asserted mid-operation discards every outstanding response. Writes accepted before reset remain committed.
- Request handshake:
  - A request transfers on a rising edge where val & rdy are both 1.
  - reqstream_rdy = (occupancy < p_depth) | (occupancy == p_depth & head deq this cycle). This combinational deq-bypass is required.
- Access timing:
  - A write commits at the accept edge.
  - A read samples the array combinationally in the accept cycle.
  - Back-to-back write then read to the same address returns the new data.
- Addressing:
  - Word index = addr[log2(p_mem_words)+1 : 2]. Higher address bits are ignored, so addresses wrap modulo 4*p_mem_words.
  - Byte offset = addr[1:0].
- Length and alignment:
  - len 1 writes byte lane offset.
  - len 2 writes lanes offset and offset+1. If offset = 3, only lane 3 is written.
  - len 0 writes all lanes and ignores the offset.
  - Reads return (word >> 8*offset) masked to len bytes.
- Response queue:
  - Circular FIFO of p_depth entries. Each entry holds {type, opaque, len, data, countdown}.
  - On enqueue, countdown is set to p_latency-1.
  - Every entry with countdown > 0 decrements by 1 each cycle.
- Response output:
  - respstream_val = queue non-empty & head countdown == 0.
  - Earliest response is valid in the cycle p_latency edges after accept. With p_latency = 1, the response is valid the cycle after accept.
  - Responses are strictly in request order.
  - Dequeue happens on a respstream val & rdy edge.
  - Output fields come from the head entry and stay stable while val=1 & rdy=0.
- Pointers and occupancy:
  - Read and write pointers wrap modulo p_depth.
  - Occupancy counter: +1 on enq, -1 on deq, unchanged when both occur in the same cycle.
- Corner cases:
  - Full with a simultaneous enq and deq: both occur and occupancy stays at p_depth.
  - Empty: respstream_val = 0.
  - Unknown type (3..7): treated as a read with no write side effects; the type is echoed.

Test Plan:
- Basic timing (p_latency=2): write addr 0x10 data 0xDEADBEEF at cycle 0, read 0x10 at cycle 1, respstream_rdy=1 -> write resp at cycle 2 with data 0; read resp at cycle 3 with data 0xDEADBEEF and opaque echoed.
- Backpressure (p_depth=4): issue 6 reads with respstream_rdy=0 -> reqstream_rdy drops after the 4th accept. Raise rdy -> 6 responses in order with opaques 0..5, none lost or duplicated.
- Subword access: write word 0x11223344 to 0x20, write byte 0xAA to 0x22 len 1 -> full-word read returns 0x11AA3344; halfword read at 0x22 returns 0x000011AA.
- Address wrap (p_mem_words=256): write 0x55 to addr 0x400 -> read of addr 0x0 returns 0x55.
- Full bypass: queue full with head valid, respstream_rdy=1 and reqstream_val=1 in the same cycle -> one deq and one enq occur, occupancy stays 4.
- Reset: assert reset with 3 responses pending -> respstream_val=0 and reqstream_rdy=0 immediately (async). After deassert, no stale responses appear and earlier writes read back correctly.
